// File: rtl/uart_hex_tx.sv
// 8N1 UART transmitter that prints a byte as two ASCII hex characters.
// Define UART_HEX_TX_CRLF_EN to append CR LF to every frame.
module uart_hex_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int UPPERCASE    = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_DV,
  input  logic [7:0] i_Byte,
  output logic       o_Ready,
  output logic       o_TX_Serial,
  output logic       o_TX_Active,
  output logic       o_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_HEX_TX_CRLF_EN
  localparam int IDX_W = 2;
`else
  localparam int IDX_W = 1;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [IDX_W-1:0] char_idx;
  logic [7:0]       byte_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       cur_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else if (UPPERCASE != 0)
      return 8'h41 + {4'h0, n} - 8'd10;
    else
      return 8'h61 + {4'h0, n} - 8'd10;
  endfunction

  always_comb begin
    cur_char = 8'h00;
`ifdef UART_HEX_TX_CRLF_EN
    case (char_idx)
      2'd0:    cur_char = hex_char(byte_reg[7:4]);
      2'd1:    cur_char = hex_char(byte_reg[3:0]);
      2'd2:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
`else
    cur_char = char_idx[0] ? hex_char(byte_reg[3:0]) : hex_char(byte_reg[7:4]);
`endif
  end

  // Outputs are registered so the line changes exactly on bit boundaries.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      char_idx    <= '0;
      byte_reg    <= '0;
      shift_reg   <= '0;
      o_TX_Serial <= 1'b1;
      o_TX_Active <= 1'b0;
      o_Done      <= 1'b0;
      o_Ready     <= 1'b1;
    end else begin
      o_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_DV) begin
            byte_reg    <= i_Byte;
            char_idx    <= '0;
            bit_cnt     <= '0;
            state       <= START;
            o_TX_Serial <= 1'b0;
            o_TX_Active <= 1'b1;
            o_Ready     <= 1'b0;
          end
        end
        START: begin
          if (bit_cnt == CNT_MAX) begin
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= cur_char;
            o_TX_Serial <= cur_char[0];
            state       <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == CNT_MAX) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_TX_Serial <= 1'b1;
              state       <= STOP;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              shift_reg   <= shift_reg >> 1;
              o_TX_Serial <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == CNT_MAX) begin
            bit_cnt <= '0;
            // Next start bit follows the stop bit with no idle gap.
            if (char_idx != LAST_IDX) begin
              char_idx    <= char_idx + 1'b1;
              o_TX_Serial <= 1'b0;
              state       <= START;
            end else begin
              o_TX_Serial <= 1'b1;
              o_TX_Active <= 1'b0;
              o_Done      <= 1'b1;
              o_Ready     <= 1'b1;
              state       <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx: one uppercase and one lowercase instance share stimulus.
// Frames are checked bit-by-bit against hand-written expected characters.
module tb_uart_hex_tx;

  localparam int CPB = 4;
`ifdef UART_HEX_TX_CRLF_EN
  localparam int N = 4;
`else
  localparam int N = 2;
`endif
  localparam int L = N * 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] byte_in = 8'h00;

  logic ready_up, tx_up, active_up, done_up;
  logic ready_lo, tx_lo, active_lo, done_lo;
  logic [1:0] ready_v, tx_v, active_v, done_v;

  int checks = 0;
  int failures = 0;

  assign ready_v  = {ready_lo, ready_up};
  assign tx_v     = {tx_lo, tx_up};
  assign active_v = {active_lo, active_up};
  assign done_v   = {done_lo, done_up};

  always #5 clk = ~clk;

  uart_hex_tx #(.CLKS_PER_BIT(CPB), .UPPERCASE(1)) dut_up (
    .i_Clk(clk), .i_Rst(rst), .i_DV(dv), .i_Byte(byte_in),
    .o_Ready(ready_up), .o_TX_Serial(tx_up), .o_TX_Active(active_up), .o_Done(done_up)
  );

  uart_hex_tx #(.CLKS_PER_BIT(CPB), .UPPERCASE(0)) dut_lo (
    .i_Clk(clk), .i_Rst(rst), .i_DV(dv), .i_Byte(byte_in),
    .o_Ready(ready_lo), .o_TX_Serial(tx_lo), .o_TX_Active(active_lo), .o_Done(done_lo)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] b);
    dv = v;
    byte_in = b;
  endtask

  task automatic checkIdle(input string name);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s/dut%0d/idle_done", name, d), 32'(done_v[d]), 32'd0);
      checkOutput($sformatf("%s/dut%0d/idle_ready", name, d), 32'(ready_v[d]), 32'd1);
      checkOutput($sformatf("%s/dut%0d/idle_line", name, d), 32'(tx_v[d]), 32'd1);
      checkOutput($sformatf("%s/dut%0d/idle_active", name, d), 32'(active_v[d]), 32'd0);
    end
  endtask

  // Called at the falling edge just after the accept edge; returns in the o_Done cycle.
  task automatic monitorFrame(input string name,
                              input logic [7:0] uh, input logic [7:0] ul,
                              input logic [7:0] lh, input logic [7:0] ll,
                              input int inject_cycle, input logic [7:0] inject_byte,
                              input bit hold, input logic [7:0] next_byte);
    logic [7:0] exp_ch [0:1][0:3];
    logic       samp [0:1][0:L-1];
    int         active_bad [0:1];
    int         done_bad [0:1];
    int         ready_bad [0:1];
    int         wave_bad [0:1];
    logic [7:0] ch;
    logic       eb;
    int         k, b;
    exp_ch[0][0] = uh; exp_ch[0][1] = ul;
    exp_ch[1][0] = lh; exp_ch[1][1] = ll;
    for (int d = 0; d < 2; d++) begin
      exp_ch[d][2] = 8'h0D;
      exp_ch[d][3] = 8'h0A;
      active_bad[d] = 0; done_bad[d] = 0; ready_bad[d] = 0; wave_bad[d] = 0;
    end
    for (int t = 0; t < L; t++) begin
      k = t / (10 * CPB);
      b = (t % (10 * CPB)) / CPB;
      for (int d = 0; d < 2; d++) begin
        samp[d][t] = tx_v[d];
        if (active_v[d] !== 1'b1) active_bad[d]++;
        if (done_v[d] !== 1'b0) done_bad[d]++;
        if (ready_v[d] !== 1'b0) ready_bad[d]++;
        if (b == 0) eb = 1'b0;
        else if (b == 9) eb = 1'b1;
        else eb = exp_ch[d][k][b-1];
        if (tx_v[d] !== eb) wave_bad[d]++;
      end
      if (hold) applyStimulus(1'b1, next_byte);
      else if (t == inject_cycle) applyStimulus(1'b1, inject_byte);
      else applyStimulus(1'b0, byte_in);
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        for (int i = 0; i < 8; i++) ch[i] = samp[d][(c * 10 + 1 + i) * CPB + CPB / 2];
        checkOutput($sformatf("%s/dut%0d/char%0d", name, d, c), 32'(ch), 32'(exp_ch[d][c]));
      end
      checkOutput($sformatf("%s/dut%0d/waveform_errs", name, d), 32'(wave_bad[d]), 32'd0);
      checkOutput($sformatf("%s/dut%0d/active_low_cycles", name, d), 32'(active_bad[d]), 32'd0);
      checkOutput($sformatf("%s/dut%0d/early_done_cycles", name, d), 32'(done_bad[d]), 32'd0);
      checkOutput($sformatf("%s/dut%0d/ready_high_cycles", name, d), 32'(ready_bad[d]), 32'd0);
      checkOutput($sformatf("%s/dut%0d/done_pulse", name, d), 32'(done_v[d]), 32'd1);
      checkOutput($sformatf("%s/dut%0d/end_active", name, d), 32'(active_v[d]), 32'd0);
      checkOutput($sformatf("%s/dut%0d/end_line", name, d), 32'(tx_v[d]), 32'd1);
      checkOutput($sformatf("%s/dut%0d/end_ready", name, d), 32'(ready_v[d]), 32'd1);
    end
    if (!hold) applyStimulus(1'b0, byte_in);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00);
    repeat (3) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;
    @(negedge clk);

    // 0xA5: hex letter in the high nibble
    applyStimulus(1'b1, 8'hA5);
    @(negedge clk);
    monitorFrame("A5", 8'h41, 8'h35, 8'h61, 8'h35, -1, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkIdle("A5");

    // 0x3F: letter case differs between the two instances
    applyStimulus(1'b1, 8'h3F);
    @(negedge clk);
    monitorFrame("3F", 8'h33, 8'h46, 8'h33, 8'h66, -1, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkIdle("3F");

    applyStimulus(1'b1, 8'h00);
    @(negedge clk);
    monitorFrame("00", 8'h30, 8'h30, 8'h30, 8'h30, -1, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkIdle("00");

    // A request mid-frame must be ignored
    applyStimulus(1'b1, 8'h9C);
    @(negedge clk);
    monitorFrame("9C", 8'h39, 8'h43, 8'h39, 8'h63, 50, 8'h11, 1'b0, 8'h00);
    @(negedge clk);
    checkIdle("9C");

    // i_DV held high: second byte taken in the o_Done cycle
    applyStimulus(1'b1, 8'h12);
    @(negedge clk);
    monitorFrame("12", 8'h31, 8'h32, 8'h31, 8'h32, -1, 8'h00, 1'b1, 8'h34);
    @(negedge clk);
    monitorFrame("34", 8'h33, 8'h34, 8'h33, 8'h34, -1, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkIdle("34");

    // Reset in the middle of character 1 of a 0xFF frame
    applyStimulus(1'b1, 8'hFF);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    for (int t = 0; t < 57; t++) @(negedge clk);
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("rst/dut%0d/active_before", d), 32'(active_v[d]), 32'd1);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst/dut%0d/line_now", d), 32'(tx_v[d]), 32'd1);
      checkOutput($sformatf("rst/dut%0d/active_now", d), 32'(active_v[d]), 32'd0);
    end
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        checkOutput($sformatf("rst/dut%0d/no_done", d), 32'(done_v[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checkIdle("post_rst");
    applyStimulus(1'b1, 8'h7E);
    @(negedge clk);
    monitorFrame("7E", 8'h37, 8'h45, 8'h37, 8'h65, -1, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkIdle("7E");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_hex_tx.md
Name: uart_hex_tx

Overview:
UART transmitter that turns a binary byte into printable ASCII hex and serialises it. It is the host-facing counterpart of the receive-and-display path: a byte shown on the two 7-segment digits is sent back as two hex characters plus an optional CR LF. The block contains its own 8N1 serialiser and character sequencer, and connects directly to the board UART TX pin.

Parameters:
CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200); legal range 2 or more.
UPPERCASE, 1, selects hex letter case: 1 gives A-F (0x41-0x46), 0 gives a-f (0x61-0x66).

Ports:
i_Clk  input  1  system clock; all logic on the rising edge.
i_Rst  input  1  asynchronous, active-high reset.
i_DV  input  1  request strobe; qualifies i_Byte.
i_Byte  input  8  byte to print.
o_Ready  output  1  high when idle and able to accept i_DV.
o_TX_Serial  output  1  UART line; idles high.
o_TX_Active  output  1  high while any character of the frame is being sent.
o_Done  output  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset, asynchronous: o_TX_Serial=1, o_TX_Active=0, o_Done=0, o_Ready=1, state=IDLE, all counters 0.
- Accept: a rising edge with i_DV=1 and o_Ready=1 latches i_Byte.
  - From that edge: o_Ready=0, o_TX_Active=1, o_TX_Serial=0 (start bit of character 0).
  - i_DV while o_Ready=0 is ignored; the latched byte is not disturbed.
- Character sequence, index 0..N-1:
  - With the CRLF macro: N=4, sent as hex(hi nibble), hex(lo nibble), 0x0D, 0x0A.
  - Without it: N=2, sent as hex(hi nibble), hex(lo nibble).
- Hex map:
  - n=0-9 gives 0x30+n.
  - n=10-15 gives 0x41+(n-10) when UPPERCASE=1, else 0x61+(n-10).
- Character frame (8N1):
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - The next character's start bit follows the previous stop bit with no idle gap.
- FSM states and transitions:
  - IDLE goes to START on accept.
  - START goes to DATA after CLKS_PER_BIT cycles.
  - DATA goes to STOP after 8 bits.
  - STOP goes to START if the character index is below N-1, else to IDLE.
- Bit-time counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Frame length: exactly N*10*CLKS_PER_BIT cycles from the accept edge to the IDLE edge.
- At the IDLE edge:
  - o_TX_Active=0, o_TX_Serial=1.
  - o_Done=1 for exactly one cycle.
  - o_Ready=1.
- Back-to-back: i_DV=1 during the o_Done cycle is accepted. Exactly one idle-high cycle separates the frames.
- Reset mid-frame:
  - Line goes high immediately; o_TX_Active=0.
  - The partial character is abandoned and no o_Done is produced.
  - The next accept starts a fresh frame at character 0.

Optional Feature:
Macro UART_HEX_TX_CRLF_EN.
- Defined: each frame appends CR (0x0D) and LF (0x0A); N=4.
- Undefined: only the two hex characters are sent; N=2. The CR/LF sequencing logic and its index state are not compiled.

Test Plan:
1. CLKS_PER_BIT=4, UPPERCASE=1, CRLF_EN defined; i_DV with 0xA5 -> line decodes 0x41, 0x35, 0x0D, 0x0A. o_TX_Active is high for exactly 160 cycles; o_Done pulses once on cycle 160 after accept.
2. UPPERCASE=0, CRLF_EN defined; byte 0x3F -> 0x33, 0x66, 0x0D, 0x0A. No idle cycles occur between characters.
3. CRLF_EN undefined, CLKS_PER_BIT=4; byte 0x00 -> 0x30, 0x30. Frame is 80 cycles and o_Done fires once.
4. During frame 0x9C, pulse i_DV with 0x11 at cycle 50 -> ignored. Line still decodes 0x39, 0x43 (plus CR LF if enabled), and o_Ready stays 0 until o_Done.
5. Hold i_DV=1 with 0x12 then 0x34 -> second byte accepted in the o_Done cycle. Exactly one high cycle separates the frames, and both frames decode correctly.
6. Assert i_Rst at cycle 57 of a 0xFF frame (mid data bit of character 1) -> o_TX_Serial=1 and o_TX_Active=0 in the same cycle, no o_Done. After release, byte 0x7E sends 0x37, 0x45 (plus CR LF if enabled).
